// File: rtl/router_if.sv
// Ingress stream plus per-port egress bus of the N-port router.
// The router connects through the slave modport; the traffic source/sink uses master.
interface router_if #(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 4
);
  logic                        data_valid;
  logic [DATA_W-1:0]           data;
  logic                        busy;
  logic [NUM_PORTS*DATA_W-1:0] port_data;
  logic [NUM_PORTS-1:0]        ready;
  logic [NUM_PORTS-1:0]        read;

  modport master (
    output data_valid, data, read,
    input  busy, port_data, ready
  );

  modport slave (
    input  data_valid, data, read,
    output busy, port_data, ready
  );
endinterface

// File: rtl/router_nport.sv
// Packet router: header beat selects an output FIFO, header and payload are queued there.
// Optional drop statistics counter enabled with the ROUTER_STATS_EN macro.
module router_nport #(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 16
) (
  input  logic        clk,
  input  logic        reset,
  router_if.slave     bus
`ifdef ROUTER_STATS_EN
  ,
  output logic [15:0] drop_cnt
`endif
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

  state_t                           state;
  logic [PW-1:0]                    dest;
  logic [CW-1:0]                    count [NUM_PORTS];
  logic [AW-1:0]                    wptr  [NUM_PORTS];
  logic [AW-1:0]                    rptr  [NUM_PORTS];
  logic [DATA_W-1:0]                mem   [NUM_PORTS][DEPTH];
  logic [NUM_PORTS-1:0][DATA_W-1:0] port_q;

  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] pop;
  logic [NUM_PORTS-1:0] push_vec;
  logic [NUM_PORTS-1:0] ready;
  logic                 hdr_ok;
  logic [PW-1:0]        hdr_idx;
  logic                 push;
  logic [PW-1:0]        sel;
  logic                 busy;

  assign hdr_ok  = bus.data < DATA_W'(NUM_PORTS);
  assign hdr_idx = bus.data[PW-1:0];

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      full[i]  = (count[i] == CW'(DEPTH));
      ready[i] = (count[i] != '0);
      pop[i]   = bus.read[i] && ready[i];
    end
  end

  // Full is judged on the start-of-cycle count, so a pop never frees room for a same-cycle push.
  always_comb begin
    busy = 1'b0;
    push = 1'b0;
    sel  = dest;
    case (state)
      IDLE: begin
        if (bus.data_valid && hdr_ok) begin
          sel = hdr_idx;
          if (full[hdr_idx]) busy = 1'b1;
          else               push = 1'b1;
        end
      end
      ROUTE: begin
        if (bus.data_valid) begin
          if (full[dest]) busy = 1'b1;
          else            push = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++)
      push_vec[i] = push && (sel == PW'(i));
  end

  assign bus.busy      = busy;
  assign bus.ready     = ready;
  assign bus.port_data = port_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      dest  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.data_valid) begin
            if (!hdr_ok) begin
              state <= DROP;
            end else if (push) begin
              state <= ROUTE;
              dest  <= hdr_idx;
            end
          end
        end
        ROUTE:   if (!bus.data_valid) state <= IDLE;
        DROP:    if (!bus.data_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROUTER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      drop_cnt <= '0;
    else if (state == IDLE && bus.data_valid && !hdr_ok && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        count[i] <= '0;
        wptr[i]  <= '0;
        rptr[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (push_vec[i]) wptr[i] <= wptr[i] + AW'(1);
        if (pop[i]) begin
          rptr[i]   <= rptr[i] + AW'(1);
          port_q[i] <= mem[i][rptr[i]];
        end
        if (push_vec[i] && !pop[i])      count[i] <= count[i] + CW'(1);
        else if (!push_vec[i] && pop[i]) count[i] <= count[i] - CW'(1);
      end
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers and counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++)
      if (push_vec[i]) mem[i][wptr[i]] <= bus.data;
  end

endmodule
